// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register between pipeline stages. Holds a payload and its control bits, and counts stall cycles.
// SKID=1 gives a two-entry skid stage whose in_ready is decoded from state only; SKID=0 gives a single register.
module pipe_stage_reg #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 6,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic              main_valid;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = main_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      state_e            state_q;
      logic [DATA_W-1:0] skid_data_q;
      logic [CTRL_W-1:0] skid_ctrl_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q     <= EMPTY;
          main_data_q <= '0;
          main_ctrl_q <= '0;
          skid_data_q <= '0;
          skid_ctrl_q <= '0;
        end else if (flush) begin
          state_q <= EMPTY;
        end else begin
          case (state_q)
            EMPTY: begin
              if (in_xfer) begin
                state_q     <= ONE;
                main_data_q <= in_data;
                main_ctrl_q <= in_ctrl;
              end
            end
            ONE: begin
              if (in_xfer && out_xfer) begin
                main_data_q <= in_data;
                main_ctrl_q <= in_ctrl;
              end else if (in_xfer) begin
                state_q     <= TWO;
                skid_data_q <= in_data;
                skid_ctrl_q <= in_ctrl;
              end else if (out_xfer) begin
                state_q <= EMPTY;
              end
            end
            TWO: begin
              // The older entry sits in main, so the skid entry is always next in line.
              if (out_xfer) begin
                state_q     <= ONE;
                main_data_q <= skid_data_q;
                main_ctrl_q <= skid_ctrl_q;
              end
            end
            default: state_q <= EMPTY;
          endcase
        end
      end

      assign main_valid = (state_q != EMPTY);
      assign in_ready   = (state_q != TWO);
    end else begin : g_flat
      logic valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q     <= 1'b0;
          main_data_q <= '0;
          main_ctrl_q <= '0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (in_xfer) begin
          valid_q     <= 1'b1;
          main_data_q <= in_data;
          main_ctrl_q <= in_ctrl;
        end else if (out_xfer) begin
          valid_q <= 1'b0;
        end
      end

      assign main_valid = valid_q;
      assign in_ready   = !valid_q | out_ready;
    end
  endgenerate

  // A bubble must never present live control bits such as MemWrite or RegWrite.
  assign out_valid = main_valid;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_valid ? main_ctrl_q : '0;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (main_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed bench for pipe_stage_reg: skid (16- and 4-bit counters) and flat variants.
// All three instances are compared every cycle against a queue model of the stage.
module tb_pipe_stage_reg;
  localparam int DW = 101;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, out_ready, flush, cnt_clr;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          in_ready_s, out_valid_s, in_ready_f, out_valid_f, in_ready_t, out_valid_t;
  logic [DW-1:0] out_data_s, out_data_f, out_data_t;
  logic [CW-1:0] out_ctrl_s, out_ctrl_f, out_ctrl_t;
  logic [15:0]   stall_s, stall_f;
  logic [3:0]    stall_t;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .in_ctrl(in_ctrl), .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_ctrl(out_ctrl_s), .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(stall_s));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_flat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_f), .in_data(in_data),
    .in_ctrl(in_ctrl), .out_valid(out_valid_f), .out_ready(out_ready), .out_data(out_data_f),
    .out_ctrl(out_ctrl_f), .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(stall_f));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t), .in_data(in_data),
    .in_ctrl(in_ctrl), .out_valid(out_valid_t), .out_ready(out_ready), .out_data(out_data_t),
    .out_ctrl(out_ctrl_t), .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(stall_t));

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } entry_t;

  // Reference: a FIFO of capacity 2 (skid) or 1 (flat) with arrival-order delivery.
  entry_t      q1[$];
  entry_t      q0[$];
  int unsigned cnt_s, cnt_f, cnt_t;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic cycle();
    entry_t e;
    bit v1, r1, v0, r0;
    #1;
    v1 = (q1.size() != 0);
    r1 = (q1.size() < 2);
    v0 = (q0.size() != 0);
    r0 = !v0 || out_ready;

    check("skid_in_ready", 128'(in_ready_s), 128'(r1));
    check("skid_out_valid", 128'(out_valid_s), 128'(v1));
    check("sat_in_ready", 128'(in_ready_t), 128'(r1));
    check("sat_out_valid", 128'(out_valid_t), 128'(v1));
    check("flat_in_ready", 128'(in_ready_f), 128'(r0));
    check("flat_out_valid", 128'(out_valid_f), 128'(v0));
    if (v1) begin
      check("skid_out_data", 128'(out_data_s), 128'(q1[0].d));
      check("skid_out_ctrl", 128'(out_ctrl_s), 128'(q1[0].c));
      check("sat_out_data", 128'(out_data_t), 128'(q1[0].d));
      check("sat_out_ctrl", 128'(out_ctrl_t), 128'(q1[0].c));
    end else begin
      check("skid_bubble_ctrl", 128'(out_ctrl_s), 128'(0));
      check("sat_bubble_ctrl", 128'(out_ctrl_t), 128'(0));
    end
    if (v0) begin
      check("flat_out_data", 128'(out_data_f), 128'(q0[0].d));
      check("flat_out_ctrl", 128'(out_ctrl_f), 128'(q0[0].c));
    end else begin
      check("flat_bubble_ctrl", 128'(out_ctrl_f), 128'(0));
    end
    check("skid_stall_cnt", 128'(stall_s), 128'(cnt_s));
    check("sat_stall_cnt", 128'(stall_t), 128'(cnt_t));
    check("flat_stall_cnt", 128'(stall_f), 128'(cnt_f));

    if (cnt_clr) begin
      cnt_s = 0; cnt_t = 0; cnt_f = 0;
    end else begin
      if (v1 && !out_ready && cnt_s < 65535) cnt_s++;
      if (v1 && !out_ready && cnt_t < 15) cnt_t++;
      if (v0 && !out_ready && cnt_f < 65535) cnt_f++;
    end

    e.d = in_data;
    e.c = in_ctrl;
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (v1 && out_ready) begin
        $display("out xfer skid data=%0h ctrl=%0h", q1[0].d, q1[0].c);
        void'(q1.pop_front());
      end
      if (in_valid && r1) q1.push_back(e);
      if (v0 && out_ready) void'(q0.pop_front());
      if (in_valid && r0) q0.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_model();
    q1.delete();
    q0.delete();
    cnt_s = 0; cnt_t = 0; cnt_f = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    in_data = '0; in_ctrl = '0;
    #1;
    check("rst_out_valid", 128'(out_valid_s), 128'(0));
    check("rst_out_ctrl", 128'(out_ctrl_s), 128'(0));
    check("rst_out_data", 128'(out_data_s), 128'(0));
    check("rst_stall_cnt", 128'(stall_s), 128'(0));
    check("rst_flat_out_data", 128'(out_data_f), 128'(0));
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    #2;
    do_reset();

    // Two entries under backpressure fill the skid, then drain in order.
    in_valid = 1'b1; out_ready = 1'b0; in_data = DW'(8'h0A); in_ctrl = 6'h09;
    cycle();
    in_data = DW'(8'h0B); in_ctrl = 6'h12;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    check("two_in_ready", 128'(in_ready_s), 128'(0));
    check("two_stall_cnt", 128'(stall_s), 128'(3));
    out_ready = 1'b1;
    repeat (3) cycle();

    // Back-to-back streaming.
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = rnd_data(); in_ctrl = CW'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("stream_stall_cnt", 128'(stall_s), 128'(0));

    // Flush while full, with a concurrent input that must be discarded.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_data = rnd_data(); in_ctrl = CW'($urandom);
      cycle();
    end
    flush = 1'b1; in_data = DW'(16'hDEAD); in_ctrl = '1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 128'(out_valid_s), 128'(0));
    check("flush_out_ctrl", 128'(out_ctrl_s), 128'(0));
    check("flush_in_ready", 128'(in_ready_s), 128'(1));
    out_ready = 1'b1;
    cycle();

    // Control bits on an idle input never reach the output.
    in_valid = 1'b0; in_ctrl = '1;
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'($urandom);
      cycle();
    end

    // Saturating stall counter, then clear.
    in_valid = 1'b1; out_ready = 1'b0; in_data = rnd_data(); in_ctrl = 6'h21;
    cycle();
    in_valid = 1'b0;
    repeat (20) cycle();
    check("sat_stall_max", 128'(stall_t), 128'(15));
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    check("sat_stall_clr", 128'(stall_t), 128'(0));
    out_ready = 1'b1;
    repeat (3) cycle();

    // Asynchronous reset between edges while holding an entry.
    in_valid = 1'b1; out_ready = 1'b0; in_data = rnd_data(); in_ctrl = '1;
    cycle();
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_skid_valid", 128'(out_valid_s), 128'(0));
    check("arst_skid_ctrl", 128'(out_ctrl_s), 128'(0));
    check("arst_flat_valid", 128'(out_valid_f), 128'(0));
    check("arst_flat_ctrl", 128'(out_ctrl_f), 128'(0));
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      cnt_clr   = ($urandom_range(0, 29) == 0);
      in_data   = rnd_data();
      in_ctrl   = CW'($urandom);
      cycle();
    end
    flush = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-002 Parameter DATA_W SHALL default to 101 and set the payload width (ext 32 + ALURes 32 + grf_out_B 32 + reg_write_no 5).
REQ-003 Parameter CTRL_W SHALL default to 6 and set the control width (Branch, MemRead, MemWrite, RegWrite, DatatoReg[1:0]).
REQ-004 Parameter SKID SHALL default to 1: 1 selects a two-entry skid stage, 0 selects a single register with a combinational ready path.
REQ-005 Parameter CNT_W SHALL default to 16 and set the stall-counter width.
REQ-006 Port clk SHALL be an input, 1 bit wide, and carry the rising-edge clock.
REQ-007 Port rst_n SHALL be an input, 1 bit wide, and act as the asynchronous active-low reset.
REQ-008 Port in_valid SHALL be an input, 1 bit wide, and mark the upstream stage presenting an entry.
REQ-009 Port in_ready SHALL be an output, 1 bit wide, and signal that the block accepts an entry this cycle.
REQ-010 Port in_data SHALL be an input, DATA_W bits wide, and carry the upstream payload.
REQ-011 Port in_ctrl SHALL be an input, CTRL_W bits wide, and carry the upstream control bits.
REQ-012 Port out_valid SHALL be an output, 1 bit wide, and mark the entry presented downstream.
REQ-013 Port out_ready SHALL be an input, 1 bit wide, and signal that the downstream stage accepts the entry.
REQ-014 Port out_data SHALL be an output, DATA_W bits wide, and carry the registered payload.
REQ-015 Port out_ctrl SHALL be an output, CTRL_W bits wide, and carry the registered control, forced to zero while out_valid=0.
REQ-016 Port flush SHALL be an input, 1 bit wide, and synchronously discard all held entries (branch/exception bubble).
REQ-017 Port cnt_clr SHALL be an input, 1 bit wide, and synchronously clear stall_cnt.
REQ-018 Port stall_cnt SHALL be an output, CNT_W bits wide, and count cycles in which out_valid=1 and out_ready=0.

Function
REQ-019 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-020 Latency from an input transfer to out_valid=1 SHALL be exactly one cycle when the stage is empty.
REQ-021 With SKID=0, in_ready SHALL equal (!out_valid | out_ready), and a simultaneous input and output transfer SHALL replace the main entry with no bubble.
REQ-022 With SKID=1, the block SHALL have states EMPTY, ONE (main valid) and TWO (main and skid valid), and in_ready SHALL equal (state != TWO), registered with no combinational path from out_ready.
REQ-023 With SKID=1, the SHALL transitions be: EMPTY->ONE on an input transfer; ONE->EMPTY on an output transfer without an input transfer; ONE->ONE on both (main replaced); ONE->TWO on an input transfer without an output transfer (entry captured in skid); TWO->ONE on an output transfer (skid moves to main).
REQ-024 Entries SHALL leave in strict arrival order, with none dropped or duplicated except by flush.
REQ-025 Flush SHALL take priority over every transfer in the same cycle: all state goes to EMPTY, any concurrent input entry is discarded, and out_valid=0 with out_ctrl=0 from the next cycle.
REQ-026 out_data SHALL hold its last value while out_valid=0, and its content in that state carries no meaning.
REQ-027 stall_cnt SHALL increment by 1 per stalled cycle and saturate at 2^CNT_W-1 without wrapping.
REQ-028 When cnt_clr and a stall coincide, cnt_clr SHALL win and stall_cnt SHALL read 0 in the next cycle.
REQ-029 A flush cycle SHALL still count as a stall if out_valid=1 and out_ready=0 in that cycle.

Reset
REQ-030 While rst_n=0, the block SHALL hold state=EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid contents=0 and stall_cnt=0, with in_ready=1 from the first cycle after rst_n rises.
REQ-031 Reset asserted mid-transfer SHALL discard all entries immediately, without waiting for a clock edge.

Verification
REQ-032 SKID=1: push in_data=0x0A, then 0x0B with out_ready=0 -> state TWO, in_ready=0, stall_cnt increments; then out_ready=1 -> outputs 0x0A followed by 0x0B in order.
REQ-033 Continuous streaming with in_valid=1 and out_ready=1 for 8 cycles -> 8 consecutive outputs, one per cycle, after one cycle of latency, with stall_cnt=0.
REQ-034 Stage in TWO state, assert flush together with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and the concurrent entry never appears at the output.
REQ-035 Set in_ctrl=6'b111111 with in_valid=0 -> out_ctrl stays 0, so a bubble never asserts MemWrite or RegWrite.
REQ-036 CNT_W=4 with out_ready=0 held for 20 cycles -> stall_cnt saturates at 15; pulse cnt_clr -> reads 0.
REQ-037 Drop rst_n between clock edges while out_valid=1 -> out_valid=0 and out_ctrl=0 immediately, and behaviour is identical for SKID=0 and SKID=1.
